// File: rtl/ccc.sv
// Cruise-control core: vehicle speed model plus cruise engage/adjust logic.
// All arithmetic saturates at 0 and 255.
module ccc (
  input  logic       clk,
  input  logic       reset,
  input  logic       throttle,
  input  logic       set,
  input  logic       accel,
  input  logic       coast,
  input  logic       cancel,
  input  logic       resume,
  input  logic       brake,
  output logic [7:0] speed,
  output logic [7:0] cruisespeed,
  output logic       cruisecontrol
);

  localparam logic [7:0] MIN_SET = 8'd45;
  localparam logic [7:0] MAX_VAL = 8'hFF;

  typedef enum logic {IDLE, CRUISE} state_t;

  state_t     state, state_n;
  logic [7:0] speed_n, cs_n;
  logic       tracking;

  assign cruisecontrol = (state == CRUISE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      speed       <= '0;
      cruisespeed <= '0;
    end else begin
      state       <= state_n;
      speed       <= speed_n;
      cruisespeed <= cs_n;
    end
  end

  // Cancel drops the vehicle into the disengaged speed rule on the same edge.
  assign tracking = (state == CRUISE) && !cancel;

  always_comb begin
    state_n = state;
    cs_n    = cruisespeed;
    speed_n = speed;

    if (brake) begin
      state_n = IDLE;
      speed_n = (speed >= 8'd2) ? speed - 8'd2 : '0;
    end else begin
      if (cancel) begin
        state_n = IDLE;
        cs_n    = '0;
      end else if (set && (speed >= MIN_SET)) begin
        state_n = CRUISE;
        cs_n    = speed;
      end else if (resume && (state == IDLE) && (cruisespeed >= MIN_SET)) begin
        state_n = CRUISE;
      end else if (accel && (state == CRUISE)) begin
        cs_n = (cruisespeed == MAX_VAL) ? cruisespeed : cruisespeed + 8'd1;
      end else if (coast && (state == CRUISE)) begin
        cs_n = (cruisespeed > MIN_SET) ? cruisespeed - 8'd1 : MIN_SET;
      end

      if (throttle) begin
        speed_n = (speed == MAX_VAL) ? speed : speed + 8'd1;
      end else if (!tracking) begin
        speed_n = (speed == 8'd0) ? speed : speed - 8'd1;
      end else if (speed < cruisespeed) begin
        speed_n = speed + 8'd1;
      end else if (speed > cruisespeed) begin
        speed_n = speed - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ccc.sv
// Scoreboard bench for ccc: directed sequences push hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_ccc;

  logic       clk = 1'b0;
  logic       reset, throttle, set, accel, coast, cancel, resume, brake;
  logic [7:0] speed, cruisespeed;
  logic       cruisecontrol;

  typedef struct {
    string      name;
    logic [7:0] sp;
    logic [7:0] cs;
    logic       cc;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  ccc dut (
    .clk(clk), .reset(reset), .throttle(throttle), .set(set), .accel(accel),
    .coast(coast), .cancel(cancel), .resume(resume), .brake(brake),
    .speed(speed), .cruisespeed(cruisespeed), .cruisecontrol(cruisecontrol)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (speed !== e.sp || cruisespeed !== e.cs || cruisecontrol !== e.cc) begin
        failed++;
        $display("FAIL %s: got speed=%0d cs=%0d cc=%0b, expected speed=%0d cs=%0d cc=%0b",
                 e.name, speed, cruisespeed, cruisecontrol, e.sp, e.cs, e.cc);
      end
    end
  end

  // inputs: throttle set accel coast cancel resume brake, held for n edges
  task automatic drive(input logic thr, input logic st, input logic acc,
                       input logic cst, input logic can, input logic res,
                       input logic brk, input int n);
    throttle = thr; set = st; accel = acc; coast = cst;
    cancel = can; resume = res; brake = brk;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] sp,
                            input logic [7:0] cs, input logic cc);
    exp_t e;
    e.name = name; e.sp = sp; e.cs = cs; e.cc = cc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, n);
  endtask

  initial begin
    reset = 1'b1;
    throttle = 0; set = 0; accel = 0; coast = 0; cancel = 0; resume = 0; brake = 0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 8'd0, 8'd0, 1'b0);
    reset = 1'b0;

    drive(1, 0, 0, 0, 0, 0, 0, 30);   expect_out("throttle30", 8'd30, 8'd0, 1'b0);
    drive(0, 1, 0, 0, 0, 0, 0, 1);    expect_out("set_below_min", 8'd29, 8'd0, 1'b0);
    idle(9);                          expect_out("decay_to_20", 8'd20, 8'd0, 1'b0);

    drive(1, 0, 0, 0, 0, 0, 0, 30);   expect_out("throttle50", 8'd50, 8'd0, 1'b0);
    drive(1, 1, 0, 0, 0, 0, 0, 1);    expect_out("set_at_50", 8'd51, 8'd50, 1'b1);
    drive(1, 0, 0, 0, 0, 0, 0, 9);    expect_out("override_to_60", 8'd60, 8'd50, 1'b1);

    drive(0, 0, 0, 0, 0, 0, 1, 1);    expect_out("brake_once", 8'd58, 8'd50, 1'b0);
    idle(28);                         expect_out("coast_to_30", 8'd30, 8'd50, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 0, 1);    expect_out("resume", 8'd29, 8'd50, 1'b1);
    idle(21);                         expect_out("ramp_to_50", 8'd50, 8'd50, 1'b1);
    idle(3);                          expect_out("hold_50", 8'd50, 8'd50, 1'b1);

    drive(0, 0, 1, 0, 0, 0, 0, 5);    expect_out("accel5", 8'd54, 8'd55, 1'b1);
    idle(1);                          expect_out("settle_55", 8'd55, 8'd55, 1'b1);
    drive(0, 0, 0, 1, 0, 0, 0, 5);    expect_out("coast5", 8'd51, 8'd50, 1'b1);
    idle(1);                          expect_out("settle_50", 8'd50, 8'd50, 1'b1);
    drive(0, 0, 0, 1, 0, 0, 0, 7);    expect_out("coast_floor_45", 8'd45, 8'd45, 1'b1);

    drive(1, 0, 0, 0, 0, 0, 0, 5);    expect_out("throttle_in_cruise", 8'd50, 8'd45, 1'b1);
    drive(0, 1, 0, 0, 0, 0, 0, 1);    expect_out("reset_while_engaged", 8'd49, 8'd50, 1'b1);
    idle(1);                          expect_out("track_new_target", 8'd50, 8'd50, 1'b1);

    drive(0, 0, 0, 0, 1, 0, 0, 1);    expect_out("cancel", 8'd49, 8'd0, 1'b0);
    idle(60);                         expect_out("idle_to_zero", 8'd0, 8'd0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);    expect_out("brake_at_zero", 8'd0, 8'd0, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 0, 1);    expect_out("resume_no_target", 8'd0, 8'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);    expect_out("speed_1", 8'd1, 8'd0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);    expect_out("brake_from_1", 8'd0, 8'd0, 1'b0);

    drive(1, 0, 0, 0, 0, 0, 0, 260);  expect_out("saturate_255", 8'd255, 8'd0, 1'b0);
    drive(1, 1, 0, 0, 0, 0, 0, 1);    expect_out("set_at_255", 8'd255, 8'd255, 1'b1);
    drive(1, 0, 1, 0, 0, 0, 0, 2);    expect_out("accel_sat", 8'd255, 8'd255, 1'b1);
    drive(1, 1, 1, 0, 0, 1, 1, 1);    expect_out("brake_priority", 8'd253, 8'd255, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 0, 1);    expect_out("resume_high", 8'd252, 8'd255, 1'b1);

    reset = 1'b1;
    drive(1, 1, 1, 0, 0, 0, 0, 1);    expect_out("reset_mid_cruise", 8'd0, 8'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);    expect_out("reset_held", 8'd0, 8'd0, 1'b0);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 1);    expect_out("after_reset", 8'd1, 8'd0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending checks, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
